regfile_read_stage: RTL

REGFILE_READ_STAGE -- requirements
Module: regfile_read_stage

---
 rtl/regfile_read_stage_pkg.sv | 11 +
 rtl/regfile_read_stage_port.sv | 33 +++
 rtl/regfile_read_stage.sv | 58 +++++
 3 files changed

// File: rtl/regfile_read_stage_pkg.sv
// regfile_read_stage_pkg: shared rv32i register-file constants and address-width helper.
package regfile_read_stage_pkg;
    localparam int RV_XLEN     = 32;
    localparam int RV_NREGS    = 32;
    localparam int RV_ZERO_REG = 1;

    // Keeps address ports at least one bit wide for degenerate single-register files.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/regfile_read_stage_port.sv
// regfile_read_port: one combinational read port with zero-register forcing and same-cycle write-back bypass.
module regfile_read_port
    import regfile_read_stage_pkg::*;
#(
    parameter int mem_width = RV_XLEN,
    parameter int mem_depth = RV_NREGS,
    parameter int zero_reg  = RV_ZERO_REG,
    localparam int AW       = addr_w(mem_depth)
) (
    input  logic [mem_width*mem_depth-1:0] reg_bus,
    input  logic [AW-1:0]                  addr,
    input  logic                           wb_we,
    input  logic [AW-1:0]                  wb_addr,
    input  logic [mem_width-1:0]           wb_data,
    output logic [mem_width-1:0]           data
);
    localparam logic [AW:0] DEPTH = (AW+1)'(mem_depth);

    logic [mem_width-1:0] regs [mem_depth];
    logic                 forced_zero;

    for (genvar i = 0; i < mem_depth; i++) begin : g_slice
        assign regs[i] = reg_bus[i*mem_width +: mem_width];
    end

    assign forced_zero = ({1'b0, addr} >= DEPTH) || (zero_reg != 0 && addr == '0);

    always_comb begin
        data = forced_zero                  ? '0 :
               (wb_we && wb_addr == addr)   ? wb_data :
                                              regs[addr];
    end
endmodule

// File: rtl/regfile_read_stage.sv
// regfile_read_stage: write-select decoder, two bypassing read ports and the operand pipeline register.
module regfile_read_stage
    import regfile_read_stage_pkg::*;
#(
    parameter int mem_width = RV_XLEN,
    parameter int mem_depth = RV_NREGS,
    parameter int zero_reg  = RV_ZERO_REG,
    localparam int AW       = addr_w(mem_depth)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [mem_width*mem_depth-1:0] reg_bus,
    input  logic [AW-1:0]                  rs1_addr,
    input  logic [AW-1:0]                  rs2_addr,
    input  logic                           in_valid,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           wb_we,
    input  logic [AW-1:0]                  wb_addr,
    input  logic [mem_width-1:0]           wb_data,
    output logic [mem_depth-1:0]           wr_sel,
    output logic [mem_width-1:0]           rs1_data,
    output logic [mem_width-1:0]           rs2_data,
    output logic                           out_valid
);
    logic [mem_width-1:0] sel1, sel2;

    // Out-of-range write addresses match no bit, so they decode to all zeros.
    for (genvar i = 0; i < mem_depth; i++) begin : g_wr_sel
        assign wr_sel[i] = wb_we && (wb_addr == AW'(i)) && !(zero_reg != 0 && i == 0);
    end

    regfile_read_port #(
        .mem_width(mem_width), .mem_depth(mem_depth), .zero_reg(zero_reg)
    ) u_port1 (
        .reg_bus(reg_bus), .addr(rs1_addr), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .data(sel1)
    );

    regfile_read_port #(
        .mem_width(mem_width), .mem_depth(mem_depth), .zero_reg(zero_reg)
    ) u_port2 (
        .reg_bus(reg_bus), .addr(rs2_addr), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .data(sel2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            out_valid <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            rs1_data  <= in_valid ? sel1 : '0;
            rs2_data  <= in_valid ? sel2 : '0;
        end
    end
endmodule
